// File: rtl/wb_port_sched.sv
// wb_port_sched: writeback port scheduler for a single register-file write port.
// Three sources compete for the port: the ALU (no buffering, highest priority),
// load returns (mem) and mul/div results (md). Mem and md each own a
// one-entry hold buffer. A starvation counter forces a slow grant after
// STARVE_LIMIT consecutive ALU wins while a slow entry waits.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data      ALU writeback request (upstream holds on alu_stall)
//   alu_stall                      ALU request not consumed this cycle
//   mem_valid/mem_rd/mem_data      load-return request, accepted when mem_ready
//   mem_ready                      mem hold entry is empty
//   md_valid/md_rd/md_data         mul/div result request, accepted when md_ready
//   md_ready                       md hold entry is empty
//   wb_en/wb_rd/wb_data/wb_src     registered write port (src: 00 ALU, 01 mem, 10 md)
module wb_port_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_src
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_MD  = 2'b10;

  logic          r_mem_hv, r_md_hv;
  logic [4:0]    r_mem_rd, r_md_rd;
  logic [31:0]   r_mem_data, r_md_data;
  logic          r_rr_md;        // 1: md wins the next mem/md contention
  logic [CW-1:0] r_starve_cnt;
  logic          r_wb_en;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;
  logic [1:0]    r_wb_src;

  logic w_any_hold, w_stall;
  logic w_grant_alu, w_grant_mem, w_grant_md;
  logic w_squash_mem, w_squash_md;
  logic w_load_mem, w_load_md;

  always_comb begin
    w_any_hold  = r_mem_hv | r_md_hv;
    w_stall     = (r_starve_cnt == LIMIT) && w_any_hold;
    w_grant_alu = alu_valid && !w_stall;
    w_grant_mem = 1'b0;
    w_grant_md  = 1'b0;
    if (!w_grant_alu) begin
      if (r_mem_hv && r_md_hv) begin
        w_grant_md  = r_rr_md;
        w_grant_mem = !r_rr_md;
      end else begin
        w_grant_mem = r_mem_hv;
        w_grant_md  = r_md_hv;
      end
    end
    // A held result is older than the ALU result to the same register, so it
    // would be overwritten anyway; drop it instead of spending a port cycle.
    w_squash_mem = w_grant_alu && r_mem_hv && (r_mem_rd == alu_rd) && (alu_rd != 5'd0);
    w_squash_md  = w_grant_alu && r_md_hv  && (r_md_rd  == alu_rd) && (alu_rd != 5'd0);
    // Incoming requests are consumed whenever ready, but not stored if they
    // collide with the register the ALU is writing this very cycle.
    w_load_mem = mem_valid && !r_mem_hv && !(w_grant_alu && (mem_rd == alu_rd));
    w_load_md  = md_valid  && !r_md_hv  && !(w_grant_alu && (md_rd  == alu_rd));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_hv     <= 1'b0;
      r_md_hv      <= 1'b0;
      r_mem_rd     <= 5'd0;
      r_md_rd      <= 5'd0;
      r_mem_data   <= 32'd0;
      r_md_data    <= 32'd0;
      r_rr_md      <= 1'b0;
      r_starve_cnt <= '0;
      r_wb_en      <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'd0;
      r_wb_src     <= SRC_ALU;
    end else begin
      if (w_grant_alu) begin
        r_wb_en   <= (alu_rd != 5'd0);
        r_wb_rd   <= alu_rd;
        r_wb_data <= alu_data;
        r_wb_src  <= SRC_ALU;
      end else if (w_grant_mem) begin
        r_wb_en   <= (r_mem_rd != 5'd0);
        r_wb_rd   <= r_mem_rd;
        r_wb_data <= r_mem_data;
        r_wb_src  <= SRC_MEM;
      end else if (w_grant_md) begin
        r_wb_en   <= (r_md_rd != 5'd0);
        r_wb_rd   <= r_md_rd;
        r_wb_data <= r_md_data;
        r_wb_src  <= SRC_MD;
      end else begin
        r_wb_en   <= 1'b0;
      end

      // Load only happens when the entry is empty, so it never overlaps a free.
      if (w_grant_mem || w_squash_mem) begin
        r_mem_hv <= 1'b0;
      end else if (w_load_mem) begin
        r_mem_hv   <= 1'b1;
        r_mem_rd   <= mem_rd;
        r_mem_data <= mem_data;
      end

      if (w_grant_md || w_squash_md) begin
        r_md_hv <= 1'b0;
      end else if (w_load_md) begin
        r_md_hv   <= 1'b1;
        r_md_rd   <= md_rd;
        r_md_data <= md_data;
      end

      // Pointer only moves on contended slow grants, so an uncontended
      // grant does not disturb whose turn it is next.
      if (w_grant_mem && r_md_hv) begin
        r_rr_md <= 1'b1;
      end else if (w_grant_md && r_mem_hv) begin
        r_rr_md <= 1'b0;
      end

      if (!w_any_hold || w_grant_mem || w_grant_md) begin
        r_starve_cnt <= '0;
      end else if (w_grant_alu && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign alu_stall = w_stall;
  assign mem_ready = !r_mem_hv;
  assign md_ready  = !r_md_hv;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign wb_src    = r_wb_src;

endmodule

// File: tb/tb_wb_port_sched.sv
module tb_wb_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, md_valid;
  logic [4:0]  alu_rd, mem_rd, md_rd;
  logic [31:0] alu_data, mem_data, md_data;
  logic        alu_stall, mem_ready, md_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_src;

  always #5 clk = ~clk;

  wb_port_sched #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_src(wb_src)
  );

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  last_rd = 5'd0;
  logic [31:0] last_data = 32'd0;
  logic [1:0]  last_src = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_in();
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    md_valid  = 1'b0; md_rd  = 5'd0; md_data  = 32'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  task automatic md(input logic [4:0] rd, input logic [31:0] d);
    md_valid = 1'b1; md_rd = rd; md_data = d;
  endtask

  // g=1: a grant is expected, so wb_* take the given values after the edge.
  // g=0: wb_en must drop and wb_rd/wb_data/wb_src hold their last values.
  task automatic step(input string tag, input bit g, input logic en, input logic [4:0] rd,
                      input logic [31:0] d, input logic [1:0] s,
                      input logic stl, input logic mr, input logic dr);
    exp_t e;
    chk({tag, ".alu_stall"}, 32'(alu_stall), 32'(stl));
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(mr));
    chk({tag, ".md_ready"},  32'(md_ready),  32'(dr));
    if (g) begin
      last_rd = rd; last_data = d; last_src = s;
      sb.push_back('{en, rd, d, s});
    end else begin
      sb.push_back('{1'b0, last_rd, last_data, last_src});
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".wb_en"},   32'(wb_en),   32'(e.en));
    chk({tag, ".wb_rd"},   32'(wb_rd),   32'(e.rd));
    chk({tag, ".wb_data"}, wb_data,      e.data);
    chk({tag, ".wb_src"},  32'(wb_src),  32'(e.src));
    idle_in();
  endtask

  initial begin
    idle_in();
    // Reset with every valid asserted: nothing may be accepted or written.
    rst = 1'b1; alu(5'd9, 32'hFFFF); mem(5'd9, 32'hEEEE); md(5'd9, 32'hDDDD);
    @(posedge clk); #1;
    rst = 1'b1; alu(5'd9, 32'hFFFF); mem(5'd9, 32'hEEEE); md(5'd9, 32'hDDDD);
    step("rst", 0, 0, 0, 0, 0, 0, 1, 1);

    // ALU only
    alu(5'd5, 32'h1234);
    step("alu", 1, 1, 5'd5, 32'h1234, 2'b00, 0, 1, 1);
    step("idle0", 0, 0, 0, 0, 0, 0, 1, 1);

    // Dual contention: mem first, then md
    mem(5'd3, 32'hAAAA); md(5'd4, 32'hBBBB);
    step("cont_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    step("cont_mem", 1, 1, 5'd3, 32'hAAAA, 2'b01, 0, 0, 0);
    step("cont_md",  1, 1, 5'd4, 32'hBBBB, 2'b10, 0, 1, 0);
    // Next contention starts with md
    mem(5'd8, 32'h11); md(5'd9, 32'h22);
    step("cont2_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    step("cont2_md",  1, 1, 5'd9, 32'h22, 2'b10, 0, 0, 0);
    step("cont2_mem", 1, 1, 5'd8, 32'h11, 2'b01, 0, 0, 1);

    // Starvation: four ALU wins while mem waits, then one forced mem grant
    mem(5'd10, 32'hCCCC); alu(5'd11, 32'h100);
    step("stv_acc", 1, 1, 5'd11, 32'h100, 2'b00, 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      alu(5'd11, 32'h100 + 32'(i));
      step($sformatf("stv_alu%0d", i), 1, 1, 5'd11, 32'h100 + 32'(i), 2'b00, 0, 0, 1);
    end
    alu(5'd11, 32'h105);
    step("stv_mem", 1, 1, 5'd10, 32'hCCCC, 2'b01, 1, 0, 1);
    alu(5'd11, 32'h105);
    step("stv_resume", 1, 1, 5'd11, 32'h105, 2'b00, 0, 1, 1);

    // WAW squash of a held md entry
    md(5'd7, 32'hDEAD);
    step("waw_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    alu(5'd7, 32'h77);
    step("waw_alu", 1, 1, 5'd7, 32'h77, 2'b00, 0, 1, 0);
    step("waw_after", 0, 0, 0, 0, 0, 0, 1, 1);

    // Incoming mem colliding with same-cycle ALU rd is dropped
    alu(5'd12, 32'h55); mem(5'd12, 32'h66);
    step("drop_alu", 1, 1, 5'd12, 32'h55, 2'b00, 0, 1, 1);
    step("drop_after", 0, 0, 0, 0, 0, 0, 1, 1);

    // Zero register
    mem(5'd0, 32'h99);
    step("r0_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    step("r0_grant", 1, 0, 5'd0, 32'h99, 2'b01, 0, 0, 1);
    step("r0_after", 0, 0, 0, 0, 0, 0, 1, 1);

    // Same rd in both holds: both written in grant order
    mem(5'd6, 32'hA1); md(5'd6, 32'hB1);
    step("same_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    step("same_mem", 1, 1, 5'd6, 32'hA1, 2'b01, 0, 0, 0);
    step("same_md",  1, 1, 5'd6, 32'hB1, 2'b10, 0, 1, 0);

    // Reset mid-flight with both holds valid (pointer currently favours md)
    mem(5'd13, 32'h13); md(5'd14, 32'h14);
    step("mrst_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    rst = 1'b1; alu(5'd15, 32'h15);
    last_rd = 5'd0; last_data = 32'd0; last_src = 2'd0;
    step("mrst", 0, 0, 0, 0, 0, 0, 0, 0);
    step("mrst_after1", 0, 0, 0, 0, 0, 0, 1, 1);
    step("mrst_after2", 0, 0, 0, 0, 0, 0, 1, 1);

    // Pointer back to mem after reset
    mem(5'd16, 32'h1); md(5'd17, 32'h2);
    step("prst_acc", 0, 0, 0, 0, 0, 0, 1, 1);
    step("prst_mem", 1, 1, 5'd16, 32'h1, 2'b01, 0, 0, 0);
    step("prst_md",  1, 1, 5'd17, 32'h2, 2'b10, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
